vga_rx_monitor: RTL and testbench

Loopback receiver/checker for the VGA pattern generator's output. It takes sync, data-enable and 24-bit RGB, all synchronous to the same clk. It then:
- auto-detects hsync and vsync polarity;
- measures line length and frame height;
- locks onto stable timing;
- publishes a per-frame pixel signature, so that pattern modes and timing modes can be self-checked on-chip or in the bench.

---
 rtl/vga_rx_pkg.sv | 26 ++
 rtl/vga_rx_monitor_meter.sv | 64 ++++++
 rtl/vga_rx_monitor.sv | 226 ++++++++++++++++++++++
 tb/tb_vga_rx_monitor.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_rx_pkg.sv
// Shared types, default widths and the frame signature step for the
// VGA loopback monitor.
package vga_rx_pkg;

    localparam int HW_DEF          = 12;
    localparam int VW_DEF          = 11;
    localparam int VRUNW_DEF       = 20;
    localparam int LOCK_FRAMES_DEF = 2;
    localparam int SIG_W           = 24;

    typedef enum logic [1:0] {
        SEARCH,
        ALIGN,
        MEASURE,
        LOCKED
    } state_e;

    // Rotate left by one, then fold in the pixel.
    function automatic logic [SIG_W-1:0] sig_step(
        input logic [SIG_W-1:0] sig,
        input logic [SIG_W-1:0] px
    );
        return {sig[SIG_W-2:0], sig[SIG_W-1]} ^ px;
    endfunction

endpackage

// File: rtl/vga_rx_monitor_meter.sv
// Sync run-length meter: learns sync polarity from the high/low run
// lengths and flags transitions into the active level.
module sync_run_meter #(
    parameter int RUNW = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic s1,
    input  logic s2,
    input  logic clear,
    output logic pol,
    output logic pol_valid,
    output logic active_edge
);

    localparam logic [RUNW-1:0] RMAX = '1;

    logic [RUNW-1:0] cnt_q;
    logic [RUNW-1:0] hi_q;
    logic [RUNW-1:0] lo_q;
    logic [RUNW-1:0] hi_d;
    logic [RUNW-1:0] lo_d;
    logic            pol_q;
    logic            edge_w;

    assign edge_w = s1 ^ s2;

    // On a transition the run that just ended belongs to the old level.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (edge_w) begin
            if (s2) hi_d = cnt_q;
            else    lo_d = cnt_q;
        end
    end

    // Run counter, stored runs and polarity; clear restarts detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            pol_q <= 1'b0;
        end else if (clear) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            pol_q <= 1'b0;
        end else if (edge_w) begin
            cnt_q <= RUNW'(1);
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            pol_q <= (hi_d < lo_d);
        end else if (cnt_q != RMAX) begin
            cnt_q <= cnt_q + RUNW'(1);
        end
    end

    assign pol         = pol_q;
    assign pol_valid   = (hi_q != '0) && (lo_q != '0);
    assign active_edge = pol_valid && edge_w && (s1 == pol_q);

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA loopback monitor: sync polarity detect, line/frame measurement,
// timing lock and per-frame pixel signature.
module vga_rx_monitor
    import vga_rx_pkg::*;
#(
    parameter int HW          = HW_DEF,
    parameter int VW          = VW_DEF,
    parameter int VRUNW       = VRUNW_DEF,
    parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    input  logic [7:0]       r,
    input  logic [7:0]       g,
    input  logic [7:0]       b,
    output logic             hsync_pol,
    output logic             vsync_pol,
    output logic [HW-1:0]    h_total,
    output logic [VW-1:0]    v_total,
    output logic [SIG_W-1:0] frame_sig,
    output logic             frame_done,
    output logic             locked,
    output logic [7:0]       err_count
);

    localparam logic [HW-1:0] HMAX = '1;
    localparam logic [VW-1:0] VMAX = '1;
    localparam logic [7:0]    EMAX = '1;
    localparam int            MW   = $clog2(LOCK_FRAMES + 1);

    logic             hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q, de_s1_q;
    logic [SIG_W-1:0] px_s1_q;
    logic             h_pol, h_pv, h_act;
    logic             v_pol, v_pv, v_act;
    logic             meter_clr;

    logic [HW-1:0]    hcnt_q, line_len_q, line_len_d, hcnt_inc;
    logic [VW-1:0]    vcnt_q, vline_d;
    logic [SIG_W-1:0] sig_q, sig_d, sig_base;
    logic             sat, same;

    state_e           state_q, state_d;
    logic [MW-1:0]    match_q, match_d, match_inc;
    logic [HW-1:0]    cap_h_q, cap_h_d;
    logic [VW-1:0]    cap_v_q, cap_v_d;
    logic             locked_q, locked_d;
    logic [7:0]       err_q, err_d;
    logic             upd;

    logic [HW-1:0]    h_total_q;
    logic [VW-1:0]    v_total_q;
    logic [SIG_W-1:0] frame_sig_q;
    logic             frame_done_q;

    // Input capture: one stage for pixel data, two for the syncs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_s1_q <= 1'b0;
            hs_s2_q <= 1'b0;
            vs_s1_q <= 1'b0;
            vs_s2_q <= 1'b0;
            de_s1_q <= 1'b0;
            px_s1_q <= '0;
        end else begin
            hs_s1_q <= hsync;
            hs_s2_q <= hs_s1_q;
            vs_s1_q <= vsync;
            vs_s2_q <= vs_s1_q;
            de_s1_q <= de;
            px_s1_q <= {r, g, b};
        end
    end

    sync_run_meter #(.RUNW(HW)) u_hmeter (
        .clk         (clk),
        .reset       (reset),
        .s1          (hs_s1_q),
        .s2          (hs_s2_q),
        .clear       (meter_clr),
        .pol         (h_pol),
        .pol_valid   (h_pv),
        .active_edge (h_act)
    );

    sync_run_meter #(.RUNW(VRUNW)) u_vmeter (
        .clk         (clk),
        .reset       (reset),
        .s1          (vs_s1_q),
        .s2          (vs_s2_q),
        .clear       (meter_clr),
        .pol         (v_pol),
        .pol_valid   (v_pv),
        .active_edge (v_act)
    );

    // A coincident hsync edge closes its line before the frame closes.
    always_comb begin
        hcnt_inc   = (hcnt_q == HMAX) ? hcnt_q : hcnt_q + HW'(1);
        line_len_d = h_act ? hcnt_q : line_len_q;
        vline_d    = vcnt_q;
        if (h_act && (vcnt_q != VMAX)) vline_d = vcnt_q + VW'(1);
        sig_base = v_act ? '0 : sig_q;
        sig_d    = de_s1_q ? sig_step(sig_base, px_s1_q) : sig_base;
        sat  = (line_len_d == HMAX) || (vline_d == VMAX);
        same = (line_len_d == cap_h_q) && (vline_d == cap_v_q);
    end

    // Line/frame counters and the running signature.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q     <= '0;
            line_len_q <= '0;
            vcnt_q     <= '0;
            sig_q      <= '0;
        end else begin
            hcnt_q     <= h_act ? HW'(1) : hcnt_inc;
            line_len_q <= line_len_d;
            vcnt_q     <= v_act ? '0 : vline_d;
            sig_q      <= sig_d;
        end
    end

    // Lock FSM: next state, lock bookkeeping and publish strobe.
    always_comb begin
        state_d   = state_q;
        match_d   = match_q;
        match_inc = match_q + MW'(1);
        cap_h_d   = cap_h_q;
        cap_v_d   = cap_v_q;
        locked_d  = locked_q;
        err_d     = err_q;
        upd       = 1'b0;
        meter_clr = 1'b0;
        unique case (state_q)
            SEARCH: begin
                if (h_pv && v_pv) state_d = ALIGN;
            end
            ALIGN: begin
                if (v_act) begin
                    match_d = '0;
                    cap_h_d = '0;
                    cap_v_d = '0;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (v_act) begin
                    upd     = 1'b1;
                    cap_h_d = line_len_d;
                    cap_v_d = vline_d;
                    if (same && !sat) begin
                        match_d = match_inc;
                        if (int'(match_inc) >= LOCK_FRAMES - 1) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (v_act) begin
                    upd     = 1'b1;
                    cap_h_d = line_len_d;
                    cap_v_d = vline_d;
                    if (!same || sat) begin
                        locked_d  = 1'b0;
                        state_d   = SEARCH;
                        meter_clr = 1'b1;
                        if (err_q != EMAX) err_d = err_q + 8'd1;
                    end
                end
            end
        endcase
    end

    // FSM state and lock bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= SEARCH;
            match_q  <= '0;
            cap_h_q  <= '0;
            cap_v_q  <= '0;
            locked_q <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            cap_h_q  <= cap_h_d;
            cap_v_q  <= cap_v_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    // Published per-frame results with a one-cycle done strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_total_q    <= '0;
            v_total_q    <= '0;
            frame_sig_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= upd;
            if (upd) begin
                h_total_q   <= line_len_d;
                v_total_q   <= vline_d;
                frame_sig_q <= sig_q;
            end
        end
    end

    assign hsync_pol  = h_pol;
    assign vsync_pol  = v_pol;
    assign h_total    = h_total_q;
    assign v_total    = v_total_q;
    assign frame_sig  = frame_sig_q;
    assign frame_done = frame_done_q;
    assign locked     = locked_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed/random bench for vga_rx_monitor using a scaled-down raster
// (40 clk/line, 20 lines/frame) and a frame-level reference model.
module tb_vga_rx_monitor;
    import vga_rx_pkg::*;

    localparam int H  = 40;
    localparam int HS = 6;
    localparam int V  = 20;
    localparam int VS = 2;
    localparam int HL = 10;
    localparam int AW = 24;
    localparam int VT = 4;
    localparam int AH = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsync, vsync, de;
    logic [7:0]  r, g, b;
    logic        hsync_pol, vsync_pol;
    logic [11:0] h_total;
    logic [10:0] v_total;
    logic [23:0] frame_sig;
    logic        frame_done, locked;
    logic [7:0]  err_count;

    vga_rx_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .r          (r),
        .g          (g),
        .b          (b),
        .hsync_pol  (hsync_pol),
        .vsync_pol  (vsync_pol),
        .h_total    (h_total),
        .v_total    (v_total),
        .frame_sig  (frame_sig),
        .frame_done (frame_done),
        .locked     (locked),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          hpos, vpos;
    int          fd_n, fd_idx;
    logic [11:0] s_h;
    logic [10:0] s_v;
    logic [23:0] s_sig;
    logic        s_lock;
    logic [7:0]  s_err;
    logic [23:0] m_sig, pub_sig;
    int          cur_last, pub_last;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        hsync = ~hpos;
        vsync = ~vpos;
        de    = 1'b0;
        {r, g, b} = 24'h0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_h"},    h_total,    0);
        check({tag, "_v"},    v_total,    0);
        check({tag, "_sig"},  frame_sig,  0);
        check({tag, "_fd"},   frame_done, 0);
        check({tag, "_lock"}, locked,     0);
        check({tag, "_err"},  err_count,  0);
        check({tag, "_hp"},   hsync_pol,  0);
        check({tag, "_vp"},   vsync_pol,  0);
    endtask

    // mode 0: black, 1: single pixel 0x123456 first, 2: random
    task automatic drive_frame(input int last_len, input int mode,
                               input int rst_line);
        int          len;
        bit          first;
        bit          d;
        logic [23:0] px;
        pub_sig  = m_sig;
        pub_last = cur_last;
        cur_last = last_len;
        m_sig    = '0;
        fd_n     = 0;
        fd_idx   = -1;
        first    = 1'b1;
        for (int y = 0; y < V; y++) begin
            len = (y == V - 1) ? last_len : H;
            for (int x = 0; x < len; x++) begin
                d  = (y >= VT) && (y < VT + AH) && (x >= HL) && (x < HL + AW);
                px = '0;
                if (d) begin
                    if (mode == 1)      px = first ? 24'h123456 : 24'h0;
                    else if (mode == 2) px = 24'($urandom);
                    first = 1'b0;
                    m_sig = sig_step(m_sig, px);
                end
                hsync = (x < HS) ? hpos : ~hpos;
                vsync = (y < VS) ? vpos : ~vpos;
                de    = d;
                {r, g, b} = px;
                @(posedge clk);
                #1;
                if (frame_done) begin
                    if (fd_n == 0) begin
                        fd_idx = y * H + x;
                        s_h    = h_total;
                        s_v    = v_total;
                        s_sig  = frame_sig;
                        s_lock = locked;
                        s_err  = err_count;
                    end
                    fd_n++;
                end
                if (y == rst_line && x == 20) begin
                    reset = 1'b1;
                    #1;
                    check_zero("async_rst");
                    @(posedge clk);
                    #1;
                    reset = 1'b0;
                end
            end
        end
    endtask

    task automatic expect_pub(input string tag, input logic lk,
                              input logic [7:0] er);
        check({tag, "_fd_n"}, fd_n, 1);
        check({tag, "_lat"},  (fd_idx >= 1 && fd_idx <= 2), 1);
        check({tag, "_h"},    s_h,    pub_last);
        check({tag, "_v"},    s_v,    V);
        check({tag, "_sig"},  s_sig,  pub_sig);
        check({tag, "_lock"}, s_lock, lk);
        check({tag, "_err"},  s_err,  er);
    endtask

    task automatic expect_none(input string tag);
        check({tag, "_no_fd"}, fd_n, 0);
    endtask

    task automatic do_reset(input bit hp, input bit vp);
        hpos  = hp;
        vpos  = vp;
        reset = 1'b1;
        idle(3);
        check_zero("reset");
        reset = 1'b0;
        m_sig    = '0;
        cur_last = H;
        idle(200);
    endtask

    initial begin
        reset = 1'b1;
        hpos  = 1'b0;
        vpos  = 1'b0;
        hsync = 1'b1;
        vsync = 1'b1;
        de    = 1'b0;
        {r, g, b} = 24'h0;
        m_sig    = '0;
        cur_last = H;

        // negative syncs, black frames
        do_reset(1'b0, 1'b0);
        drive_frame(H, 0, -1);
        check("neg_hpol", hsync_pol, 0);
        check("neg_vpol", vsync_pol, 0);
        expect_none("neg_f0");
        drive_frame(H, 0, -1);
        expect_none("neg_align");
        drive_frame(H, 0, -1);
        expect_pub("neg_m1", 1'b0, 8'd0);
        drive_frame(H, 1, -1);
        expect_pub("neg_lock", 1'b1, 8'd0);
        drive_frame(H, 2, -1);
        expect_pub("pix", 1'b1, 8'd0);
        check("pix_const", s_sig, 24'h091A2B);
        drive_frame(H - 1, 2, -1);
        expect_pub("rand1", 1'b1, 8'd0);

        // short last line breaks lock
        drive_frame(H, 2, -1);
        expect_pub("short", 1'b0, 8'd1);
        check("short_h", s_h, H - 1);
        check("short_lock_now", locked, 0);
        drive_frame(H, 0, -1);
        expect_none("rl_redetect");
        drive_frame(H, 0, -1);
        expect_none("rl_align");
        drive_frame(H, 2, -1);
        expect_pub("rl_m1", 1'b0, 8'd1);
        drive_frame(H, 0, -1);
        expect_pub("rl_lock", 1'b1, 8'd1);

        // asynchronous reset in the middle of a locked frame
        drive_frame(H, 0, 10);
        expect_pub("pre_rst", 1'b1, 8'd1);
        drive_frame(H, 0, -1);
        expect_none("ar_redetect");
        drive_frame(H, 2, -1);
        expect_none("ar_align");
        drive_frame(H, 0, -1);
        expect_pub("ar_m1", 1'b0, 8'd0);
        drive_frame(H, 0, -1);
        expect_pub("ar_lock", 1'b1, 8'd0);

        // positive syncs
        do_reset(1'b1, 1'b1);
        drive_frame(H, 2, -1);
        check("pos_hpol", hsync_pol, 1);
        check("pos_vpol", vsync_pol, 1);
        expect_none("pos_f0");
        drive_frame(H, 2, -1);
        expect_none("pos_align");
        drive_frame(H, 2, -1);
        expect_pub("pos_m1", 1'b0, 8'd0);
        drive_frame(H, 2, -1);
        expect_pub("pos_lock", 1'b1, 8'd0);
        drive_frame(H, 0, -1);
        expect_pub("pos_rand", 1'b1, 8'd0);
        check("pos_hpol_end", hsync_pol, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
